// File: rtl/stim_seq_pkg.sv
// ============================================================================
// Module   : stim_seq_pkg
// Brief    : Shared types, default sizes and entry field helpers for stim_seq.
// Revision : 1.0
// ============================================================================
`default_nettype none

package stim_seq_pkg;

    localparam int c_default_pw    = 14;
    localparam int c_default_hw    = 4;
    localparam int c_default_depth = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PLAY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Entries are {hold, payload}; widths are passed in so one helper serves any build.
    function automatic logic [63:0] f_payload(input logic [63:0] entry, input int pw);
        return entry & ((64'd1 << pw) - 64'd1);
    endfunction

    function automatic logic [63:0] f_hold(input logic [63:0] entry, input int pw, input int hw);
        return (entry >> pw) & ((64'd1 << hw) - 64'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/stim_seq_if.sv
// ============================================================================
// Module   : stim_seq_if
// Brief    : Program-load bus and stimulus output bundle of stim_seq.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface stim_seq_if
    import stim_seq_pkg::*;
#(
    parameter int PW = c_default_pw,
    parameter int HW = c_default_hw,
    parameter int AW = $clog2(c_default_depth)
);
    logic               cfg_we;
    logic [AW-1:0]      cfg_addr;
    logic [PW+HW-1:0]   cfg_wdata;
    logic [PW-1:0]      stim_out;
    logic               stim_valid;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata,
        input  stim_out, stim_valid
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata,
        output stim_out, stim_valid
    );
endinterface

`default_nettype wire

// File: rtl/stim_seq_ram.sv
// ============================================================================
// Module   : stim_seq_ram
// Brief    : Simple dual-port program RAM, one write port, one registered read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stim_seq_ram #(
    parameter int DW    = 18,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  wire logic          clk,
    input  wire logic          i_we,
    input  wire logic [AW-1:0] i_waddr,
    input  wire logic [DW-1:0] i_wdata,
    input  wire logic          i_re,
    input  wire logic [AW-1:0] i_raddr,
    output logic [DW-1:0]      o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Contents are deliberately never reset so a playback abort keeps the program.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/stim_seq.sv
// ============================================================================
// Module   : stim_seq
// Brief    : Programmable stimulus sequencer; plays {hold,payload} entries.
//            Optional trace outputs enabled by macro STIM_SEQ_TRACE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stim_seq
    import stim_seq_pkg::*;
#(
    parameter int  PW    = c_default_pw,
    parameter int  HW    = c_default_hw,
    parameter int  DEPTH = c_default_depth,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    stim_seq_if.slave          bus,
    input  wire logic          start,
    input  wire logic          stop,
    input  wire logic          loop_en,
    input  wire logic [AW-1:0] last_addr,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      pc
`ifdef STIM_SEQ_TRACE_EN
    ,
    output logic               trace_valid,
    output logic [AW-1:0]      trace_pc
`endif
);
    localparam int c_ew = PW + HW;

    state_t          r_state;
    logic            r_rst_sync;
    logic [PW-1:0]   r_stim_out;
    logic            r_stim_valid;
    logic            r_done;
    logic [AW-1:0]   r_pc;
    logic [HW-1:0]   r_hold;
    logic            r_loop;
    logic [AW-1:0]   r_last;
    logic [AW-1:0]   r_fidx;
    logic [AW-1:0]   r_ridx;
    logic            r_fmore;
    logic            r_rvld;

    logic [c_ew-1:0] w_rdata;
    logic [AW-1:0]   w_last_clamped;
    logic            w_addr_ok;
    logic            w_busy, w_stop, w_start, w_adv, w_load, w_re, w_we;
    logic [PW-1:0]   w_rd_pay;
    logic [HW-1:0]   w_rd_hold;

    assign w_busy    = (r_state == ST_FETCH) || (r_state == ST_PLAY);
    assign w_stop    = stop && w_busy;
    assign w_start   = start && !stop && !w_busy && r_rst_sync;
    // Advance when the shown entry is on its final cycle, or nothing is shown yet.
    assign w_adv     = (r_state == ST_PLAY) && (!r_stim_valid || (r_hold == '0));
    assign w_load    = w_adv && r_rvld && !w_stop;
    assign w_re      = ((r_state == ST_FETCH) || w_adv) && r_fmore && !w_stop;
    assign w_we      = bus.cfg_we && !w_busy && w_addr_ok;
    assign w_rd_pay  = PW'(f_payload(64'(w_rdata), PW));
    assign w_rd_hold = HW'(f_hold(64'(w_rdata), PW, HW));

    if (DEPTH == (1 << AW)) begin : g_pow2
        assign w_last_clamped = last_addr;
        assign w_addr_ok      = 1'b1;
    end else begin : g_clamp
        assign w_last_clamped = (last_addr > AW'(DEPTH - 1)) ? AW'(DEPTH - 1) : last_addr;
        assign w_addr_ok      = (bus.cfg_addr < AW'(DEPTH));
    end

    stim_seq_ram #(
        .DW    (c_ew),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (bus.cfg_addr),
        .i_wdata (bus.cfg_wdata),
        .i_re    (w_re),
        .i_raddr (r_fidx),
        .o_rdata (w_rdata)
    );

    // Async assert, release qualified by one flop: start is honoured from the second edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rst_sync <= 1'b0;
        else      r_rst_sync <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_stim_out   <= '0;
            r_stim_valid <= 1'b0;
            r_done       <= 1'b0;
            r_pc         <= '0;
            r_hold       <= '0;
            r_loop       <= 1'b0;
            r_last       <= '0;
            r_fidx       <= '0;
            r_ridx       <= '0;
            r_fmore      <= 1'b0;
            r_rvld       <= 1'b0;
        end else if (w_stop) begin
            r_state      <= ST_IDLE;
            r_stim_out   <= '0;
            r_stim_valid <= 1'b0;
            r_done       <= 1'b0;
            r_hold       <= '0;
            r_fmore      <= 1'b0;
            r_rvld       <= 1'b0;
        end else if (w_start) begin
            r_state      <= ST_FETCH;
            r_pc         <= '0;
            r_last       <= w_last_clamped;
            r_loop       <= loop_en;
            r_fidx       <= '0;
            r_fmore      <= 1'b1;
            r_rvld       <= 1'b0;
            r_done       <= 1'b0;
            r_hold       <= '0;
        end else begin
            case (r_state)
                ST_FETCH: r_state <= ST_PLAY;
                ST_PLAY: begin
                    if (w_adv) begin
                        if (r_rvld) begin
                            r_stim_out   <= w_rd_pay;
                            r_hold       <= w_rd_hold;
                            r_pc         <= r_ridx;
                            r_stim_valid <= 1'b1;
                        end else begin
                            r_state      <= ST_DONE;
                            r_stim_valid <= 1'b0;
                            r_done       <= 1'b1;
                        end
                    end else begin
                        r_hold <= r_hold - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.cfg_we) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: ;
            endcase

            // Read stage runs one entry ahead of stim_out so entries play back-to-back.
            if (w_re) begin
                r_ridx <= r_fidx;
                r_rvld <= 1'b1;
                r_fidx <= (r_fidx == r_last) ? '0 : r_fidx + 1'b1;
                if ((r_fidx == r_last) && !r_loop) begin
                    r_fmore <= 1'b0;
                end
            end else if (w_adv) begin
                r_rvld <= 1'b0;
            end
        end
    end

    assign bus.stim_out   = r_stim_out;
    assign bus.stim_valid = r_stim_valid;
    assign busy           = w_busy;
    assign done           = r_done;
    assign pc             = r_pc;

`ifdef STIM_SEQ_TRACE_EN
    logic          r_trace_valid;
    logic [AW-1:0] r_trace_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_trace_valid <= 1'b0;
            r_trace_pc    <= '0;
        end else begin
            r_trace_valid <= w_load;
            if (w_load) begin
                r_trace_pc <= r_ridx;
            end
        end
    end

    assign trace_valid = r_trace_valid;
    assign trace_pc    = r_trace_pc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stim_seq.sv
// ============================================================================
// Module   : tb_stim_seq
// Brief    : Self-checking bench for stim_seq (DEPTH=20), table plus sequences.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stim_seq;
    localparam int PW    = 14;
    localparam int HW    = 4;
    localparam int DEPTH = 20;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop_en = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic          busy, done;
    logic [AW-1:0] pc;
`ifdef STIM_SEQ_TRACE_EN
    logic          trace_valid;
    logic [AW-1:0] trace_pc;
`endif

    stim_seq_if #(.PW(PW), .HW(HW), .AW(AW)) bus();

    stim_seq #(.PW(PW), .HW(HW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .start       (start),
        .stop        (stop),
        .loop_en     (loop_en),
        .last_addr   (last_addr),
        .busy        (busy),
        .done        (done),
        .pc          (pc)
`ifdef STIM_SEQ_TRACE_EN
        ,
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic          start, stop, loop;
        logic [AW-1:0] last;
        logic          valid;
        logic [PW-1:0] stim;
        logic          chk_pc;
        logic [AW-1:0] pc;
        logic          busy, done;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(input logic s, input logic p, input logic l, input int la,
                               input logic vl, input int st, input logic cp, input int pcv,
                               input logic b, input logic d);
        vec_t r;
        r.start = s; r.stop = p; r.loop = l; r.last = AW'(la);
        r.valid = vl; r.stim = PW'(st); r.chk_pc = cp; r.pc = AW'(pcv);
        r.busy = b; r.done = d;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int h, input int p);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = AW'(a);
        bus.cfg_wdata = {HW'(h), PW'(p)};
        tick();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic run_to_done(input string name);
        bit ok = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (done) begin ok = 1; break; end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;

        // Reset values, observed before any clock edge.
        #2;
        chk("rst_valid", 32'(bus.stim_valid), 0);
        chk("rst_stim",  32'(bus.stim_out), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_pc",    32'(pc), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick(); tick();

        wr(0, 0, 'h011);
        wr(1, 2, 'h022);
        wr(2, 0, 'h033);
        wr(3, 15, 'h103);
        for (int i = 4; i < DEPTH; i++) wr(i, 0, 'h100 + i);

        // One-shot (loop/last changed mid-run must be ignored), then loop, stop, start+stop.
        vt.push_back(v(1,0,0,2, 0,'h000,1,0, 1,0));
        vt.push_back(v(0,0,0,2, 0,'h000,1,0, 1,0));
        vt.push_back(v(0,0,0,2, 1,'h011,1,0, 1,0));
        vt.push_back(v(0,0,1,5, 1,'h022,1,1, 1,0));
        vt.push_back(v(0,0,1,5, 1,'h022,1,1, 1,0));
        vt.push_back(v(0,0,1,5, 1,'h022,1,1, 1,0));
        vt.push_back(v(0,0,1,5, 1,'h033,1,2, 1,0));
        vt.push_back(v(0,0,1,5, 0,'h033,1,2, 0,1));
        vt.push_back(v(0,0,0,2, 0,'h033,1,2, 0,1));
        vt.push_back(v(1,0,1,2, 0,'h033,1,0, 1,0));
        vt.push_back(v(0,0,0,7, 0,'h033,1,0, 1,0));
        vt.push_back(v(0,0,0,7, 1,'h011,1,0, 1,0));
        vt.push_back(v(0,0,0,7, 1,'h022,1,1, 1,0));
        vt.push_back(v(0,0,0,7, 1,'h022,1,1, 1,0));
        vt.push_back(v(0,0,0,7, 1,'h022,1,1, 1,0));
        vt.push_back(v(0,0,0,7, 1,'h033,1,2, 1,0));
        vt.push_back(v(0,0,0,7, 1,'h011,1,0, 1,0));
        vt.push_back(v(0,0,0,7, 1,'h022,1,1, 1,0));
        vt.push_back(v(0,0,0,7, 1,'h022,1,1, 1,0));
        vt.push_back(v(0,1,0,0, 0,'h000,0,0, 0,0));
        vt.push_back(v(1,1,1,2, 0,'h000,0,0, 0,0));
        vt.push_back(v(0,0,0,2, 0,'h000,0,0, 0,0));
        vt.push_back(v(0,0,0,2, 0,'h000,0,0, 0,0));

        for (int i = 0; i < vt.size(); i++) begin
            start = vt[i].start; stop = vt[i].stop;
            loop_en = vt[i].loop; last_addr = vt[i].last;
            tick();
            chk($sformatf("v%0d_valid", i), 32'(bus.stim_valid), 32'(vt[i].valid));
            chk($sformatf("v%0d_stim", i),  32'(bus.stim_out),   32'(vt[i].stim));
            chk($sformatf("v%0d_busy", i),  32'(busy),           32'(vt[i].busy));
            chk($sformatf("v%0d_done", i),  32'(done),           32'(vt[i].done));
            if (vt[i].chk_pc) chk($sformatf("v%0d_pc", i), 32'(pc), 32'(vt[i].pc));
        end
        start = 0; stop = 0; loop_en = 0; last_addr = 5'd2;

        // Write attempt during PLAY must not reach memory.
        start = 1; tick(); start = 0; tick(); tick();
        wr(0, 0, 'h3FFF);
        run_to_done("wplay_done");
        wr(25, 0, 0);
        chk("cfg_in_done_done", 32'(done), 0);
        chk("cfg_in_done_busy", 32'(busy), 0);
        start = 1; tick(); start = 0; tick(); tick();
        chk("rerun_valid", 32'(bus.stim_valid), 1);
        chk("rerun_stim",  32'(bus.stim_out), 'h011);

        // Mid-run reset clears outputs asynchronously; start only from the second edge.
        tick(); tick();
        rst = 1'b0;
        #2;
        chk("mrst_valid", 32'(bus.stim_valid), 0);
        chk("mrst_stim",  32'(bus.stim_out), 0);
        chk("mrst_busy",  32'(busy), 0);
        chk("mrst_done",  32'(done), 0);
        chk("mrst_pc",    32'(pc), 0);
        @(posedge clk); #1;
        rst = 1'b1; start = 1;
        tick();
        chk("rsync_edge1_ignored", 32'(busy), 0);
        tick();
        start = 0;
        chk("rsync_edge2_accepted", 32'(busy), 1);
        tick(); tick();
        chk("postrst_stim", 32'(bus.stim_out), 'h011);
        run_to_done("postrst_done");

        // Out-of-range last_addr clamps to the final entry.
        begin
            int vcnt = 0, n103 = 0, gaps = 0, tcnt = 0;
            bit seen = 0, ok = 0;
            loop_en = 0; last_addr = 5'h1F; start = 1;
            tick();
            start = 0;
            for (int c = 0; c < 200; c++) begin
`ifdef STIM_SEQ_TRACE_EN
                if (trace_valid) begin
                    chk($sformatf("trace_pc_%0d", tcnt), 32'(trace_pc), 32'(tcnt));
                    tcnt++;
                end
`endif
                if (done) begin ok = 1; break; end
                if (bus.stim_valid) begin
                    vcnt++; seen = 1;
                    if (bus.stim_out == PW'('h103)) n103++;
                end else if (seen) begin
                    gaps++;
                end
                tick();
            end
            chk("long_done",   32'(ok), 1);
            chk("long_vcnt",   32'(vcnt), 37);
            chk("long_hold15", 32'(n103), 16);
            chk("long_gaps",   32'(gaps), 0);
            chk("long_stim",   32'(bus.stim_out), 'h113);
            chk("long_pc",     32'(pc), 19);
`ifdef STIM_SEQ_TRACE_EN
            chk("trace_count", 32'(tcnt), 20);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
